// File: rtl/aes_pkg.sv
// Shared AES definitions: AES-192 sizes, Rcon table, RotWord and round-key slice helper.
// Used by both the key expansion stage and the data-path core.
package aes_pkg;

  localparam int AES192_NK = 6;
  localparam int AES192_NR = 12;
  localparam int AES192_NW = 4 * (AES192_NR + 1);

  // Rcon[j] for j = 1..10; index 0 is unused and returns 0.
  function automatic logic [7:0] rcon_byte(input logic [3:0] j);
    logic [7:0] r;
    case (j)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // LSB position of round key k inside the flattened schedule bus.
  function automatic int rk_lsb(input int k);
    return 128 * (AES192_NR - k);
  endfunction

endpackage

// File: rtl/aes192_kex_grp.sv
// Combinational AES-192 group generator: derives the next 6 schedule words from the
// previous group, the external S-box result for RotWord(last word), and Rcon.
module aes192_kex_grp
  import aes_pkg::*;
(
  input  logic [32*AES192_NK-1:0] prev_grp,
  input  logic [31:0]             sbox_dout,
  input  logic [7:0]              rcon,
  output logic [32*AES192_NK-1:0] next_grp
);

  logic [31:0] t;
  logic [31:0] p [AES192_NK];
  logic [31:0] n [AES192_NK];

  assign t = sbox_dout ^ {rcon, 24'h0};

  always_comb begin
    for (int m = 0; m < AES192_NK; m++) begin
      p[m] = prev_grp[32*(AES192_NK-1-m) +: 32];
    end
    n[0] = p[0] ^ t;
    for (int m = 1; m < AES192_NK; m++) begin
      n[m] = p[m] ^ n[m-1];
    end
    next_grp = '0;
    for (int m = 0; m < AES192_NK; m++) begin
      next_grp[32*(AES192_NK-1-m) +: 32] = n[m];
    end
  end

endmodule

// File: rtl/aes192_kex.sv
// AES-192 key expansion: one 6-word group per clock, schedule held static and flagged
// valid until the next key load. The S-box is external and shared with the data path.
//
// state     | meaning
// ST_IDLE   | r_count = 0; schedule held, o_key_ok reflects last completed load
// ST_EXPAND | r_count = 1..8; group r_count written on each edge
module aes192_kex
  import aes_pkg::*;
#(
  parameter int NK = AES192_NK,
  parameter int NW = AES192_NW
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [32*NK-1:0]  i_key,
  input  logic              i_key_en,
  output logic [32*NW-1:0]  o_keyex,
  output logic              o_key_ok,
  output logic              o_busy,
  output logic [31:0]       o_sbox_din,
  input  logic [31:0]       i_sbox_dout
);

  typedef enum logic {ST_IDLE, ST_EXPAND} kex_state_t;

  localparam int LAST_GRP = (NW - 1) / NK;

  kex_state_t  state_q, state_d;
  logic [3:0]  r_count_q, r_count_d;
  logic        key_ok_q, key_ok_d;
  logic [31:0] w_q [NW];
  logic [31:0] w_d [NW];
  logic [32*NK-1:0] grp_prev;
  logic [32*NK-1:0] grp_new;

  // Previous group is the one r_count is about to extend; zero when idle.
  always_comb begin
    grp_prev = '0;
    for (int j = 1; j <= LAST_GRP; j++) begin
      if (r_count_q == 4'(j)) begin
        for (int m = 0; m < NK; m++) begin
          grp_prev[32*(NK-1-m) +: 32] = w_q[NK*(j-1)+m];
        end
      end
    end
  end

  assign o_sbox_din = rot_word(grp_prev[31:0]);

  aes192_kex_grp u_grp (
    .prev_grp  (grp_prev),
    .sbox_dout (i_sbox_dout),
    .rcon      (rcon_byte(r_count_q)),
    .next_grp  (grp_new)
  );

  always_comb begin
    state_d   = state_q;
    r_count_d = r_count_q;
    key_ok_d  = key_ok_q;
    w_d       = w_q;
    if (i_key_en) begin
      state_d   = ST_EXPAND;
      r_count_d = 4'd1;
      key_ok_d  = 1'b0;
      for (int i = 0; i < NK; i++) begin
        w_d[i] = i_key[32*(NK-1-i) +: 32];
      end
    end else if (state_q == ST_EXPAND) begin
      // Last group is truncated naturally: only indices below NW exist.
      for (int i = NK; i < NW; i++) begin
        if (r_count_q == 4'(i / NK)) begin
          w_d[i] = grp_new[32*(NK-1-(i%NK)) +: 32];
        end
      end
      if (r_count_q == 4'(LAST_GRP)) begin
        state_d   = ST_IDLE;
        r_count_d = 4'd0;
        key_ok_d  = 1'b1;
      end else begin
        r_count_d = r_count_q + 4'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      r_count_q <= 4'd0;
      key_ok_q  <= 1'b0;
      for (int i = 0; i < NW; i++) begin
        w_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      r_count_q <= r_count_d;
      key_ok_q  <= key_ok_d;
      w_q       <= w_d;
    end
  end

  for (genvar gi = 0; gi < NW; gi++) begin : g_out
    assign o_keyex[32*(NW-1-gi) +: 32] = w_q[gi];
  end

  assign o_key_ok = key_ok_q;
  assign o_busy   = (state_q == ST_EXPAND);

endmodule

// File: tb/tb_aes192_kex.sv
// Directed bench for aes192_kex using the FIPS-197 A.2 AES-192 key and a local S-box table.
module tb_aes192_kex;

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic [191:0]   i_key;
  logic           i_key_en;
  logic [1663:0]  o_keyex;
  logic           o_key_ok;
  logic           o_busy;
  logic [31:0]    o_sbox_din;
  logic [31:0]    i_sbox_dout;

  int total = 0;
  int bad = 0;

  localparam logic [191:0] KEY_A2  = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [191:0] KEY_ZERO = 192'h0;
  localparam logic [31:0]  EXP_W6  = 32'hfe0c91f7;
  localparam logic [31:0]  EXP_W7  = 32'h2402f5a5;
  localparam logic [127:0] EXP_RK12 = 128'he98ba06f448c773c8ecc720401002202;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  always_comb begin
    i_sbox_dout = {SBOX[o_sbox_din[31:24]], SBOX[o_sbox_din[23:16]],
                   SBOX[o_sbox_din[15:8]],  SBOX[o_sbox_din[7:0]]};
  end

  always #5 i_clk = ~i_clk;

  aes192_kex dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_key       (i_key),
    .i_key_en    (i_key_en),
    .o_keyex     (o_keyex),
    .o_key_ok    (o_key_ok),
    .o_busy      (o_busy),
    .o_sbox_din  (o_sbox_din),
    .i_sbox_dout (i_sbox_dout)
  );

  function automatic logic [31:0] word_at(input logic [1663:0] bus, input int i);
    return bus[32*(51-i) +: 32];
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic load_key(input logic [191:0] k);
    i_key    = k;
    i_key_en = 1'b1;
    step();
    i_key_en = 1'b0;
  endtask

  // Counts edges after the load edge until o_key_ok, plus how many sampled cycles were busy.
  task automatic wait_ok(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!o_key_ok && lat < 20) begin
      if (o_busy) busy_cnt++;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    step();
    step();
    i_rst = 1'b0;
    total++; if (o_keyex !== '0) begin bad++; $display("FAIL reset_keyex got nonzero expected 0"); end
    total++; if (o_key_ok !== 1'b0) begin bad++; $display("FAIL reset_key_ok got %b expected 0", o_key_ok); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b expected 0", o_busy); end
  endtask

  task automatic test_fips_a2();
    int lat, bc;
    load_key(KEY_A2);
    total++; if (o_sbox_din !== 32'h2c6b7b52) begin bad++; $display("FAIL a2_sbox_din got %h expected 2c6b7b52", o_sbox_din); end
    wait_ok(lat, bc);
    total++; if (lat !== 8) begin bad++; $display("FAIL a2_latency got %0d expected 8", lat); end
    total++; if (bc !== 8) begin bad++; $display("FAIL a2_busy_cycles got %0d expected 8", bc); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL a2_busy_done got %b expected 0", o_busy); end
    total++; if (word_at(o_keyex, 6) !== EXP_W6) begin bad++; $display("FAIL a2_w6 got %h expected %h", word_at(o_keyex, 6), EXP_W6); end
    total++; if (word_at(o_keyex, 7) !== EXP_W7) begin bad++; $display("FAIL a2_w7 got %h expected %h", word_at(o_keyex, 7), EXP_W7); end
    total++; if (o_keyex[127:0] !== EXP_RK12) begin bad++; $display("FAIL a2_rk12 got %h expected %h", o_keyex[127:0], EXP_RK12); end
    total++; if (o_keyex[1663:1472] !== KEY_A2) begin bad++; $display("FAIL a2_key_words got %h expected %h", o_keyex[1663:1472], KEY_A2); end
  endtask

  task automatic test_hold();
    repeat (20) step();
    total++; if (o_key_ok !== 1'b1) begin bad++; $display("FAIL hold_key_ok got %b expected 1", o_key_ok); end
    total++; if (o_keyex[127:0] !== EXP_RK12) begin bad++; $display("FAIL hold_rk12 got %h expected %h", o_keyex[127:0], EXP_RK12); end
  endtask

  task automatic test_restart_mid();
    int lat, bc;
    load_key(KEY_ZERO);
    repeat (3) step();
    load_key(KEY_A2);
    total++; if (o_key_ok !== 1'b0) begin bad++; $display("FAIL restart_ok_low got %b expected 0", o_key_ok); end
    wait_ok(lat, bc);
    total++; if (lat !== 8) begin bad++; $display("FAIL restart_latency got %0d expected 8", lat); end
    total++; if (word_at(o_keyex, 6) !== EXP_W6) begin bad++; $display("FAIL restart_w6 got %h expected %h", word_at(o_keyex, 6), EXP_W6); end
    total++; if (word_at(o_keyex, 7) !== EXP_W7) begin bad++; $display("FAIL restart_w7 got %h expected %h", word_at(o_keyex, 7), EXP_W7); end
    total++; if (o_keyex[127:0] !== EXP_RK12) begin bad++; $display("FAIL restart_rk12 got %h expected %h", o_keyex[127:0], EXP_RK12); end
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    load_key(KEY_A2);
    repeat (4) step();
    i_rst = 1'b1;
    i_key_en = 1'b1;
    step();
    i_rst = 1'b0;
    i_key_en = 1'b0;
    total++; if (o_keyex !== '0) begin bad++; $display("FAIL rstmid_keyex got nonzero expected 0"); end
    total++; if (o_key_ok !== 1'b0) begin bad++; $display("FAIL rstmid_key_ok got %b expected 0", o_key_ok); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got %b expected 0", o_busy); end
    load_key(KEY_A2);
    wait_ok(lat, bc);
    total++; if (lat !== 8) begin bad++; $display("FAIL rstmid_latency got %0d expected 8", lat); end
    total++; if (o_keyex[127:0] !== EXP_RK12) begin bad++; $display("FAIL rstmid_rk12 got %h expected %h", o_keyex[127:0], EXP_RK12); end
    total++; if (word_at(o_keyex, 6) !== EXP_W6) begin bad++; $display("FAIL rstmid_w6 got %h expected %h", word_at(o_keyex, 6), EXP_W6); end
  endtask

  task automatic test_restart_at_e8();
    int lat, bc;
    load_key(KEY_ZERO);
    repeat (7) step();
    load_key(KEY_A2);
    total++; if (o_key_ok !== 1'b0) begin bad++; $display("FAIL e8_ok_low got %b expected 0", o_key_ok); end
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL e8_busy got %b expected 1", o_busy); end
    wait_ok(lat, bc);
    total++; if (lat !== 8) begin bad++; $display("FAIL e8_latency got %0d expected 8", lat); end
    total++; if (word_at(o_keyex, 7) !== EXP_W7) begin bad++; $display("FAIL e8_w7 got %h expected %h", word_at(o_keyex, 7), EXP_W7); end
    total++; if (o_keyex[127:0] !== EXP_RK12) begin bad++; $display("FAIL e8_rk12 got %h expected %h", o_keyex[127:0], EXP_RK12); end
  endtask

  initial begin
    i_rst    = 1'b1;
    i_key    = '0;
    i_key_en = 1'b0;
    test_reset();
    test_fips_a2();
    test_hold();
    test_restart_mid();
    test_reset_mid();
    test_restart_at_e8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes192_kex.md
Name: aes192_kex

Overview:
AES-192 key expansion stage. It sits directly upstream of the AES-192 data-path core and produces the 13 round keys (52 words) that the core consumes on its i_keyex bus. It computes one 6-word group per clock. SubWord uses the same external combinational S-box port style as the data path, 32 bits wide. It holds the expanded schedule static and flags it valid until the next key load.

Parameters:
NK, 6, key length in 32-bit words (fixed for AES-192; not intended to be overridden)
NW, 52, total expanded words = 4*(NR+1), NR=12

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset; synchronous, active-high
i_key  in  192  cipher key; w0 = i_key[191:160] ... w5 = i_key[31:0]
i_key_en  in  1  one-cycle load strobe; i_key sampled on same edge
o_keyex  out  1664  expanded schedule; round key k occupies [128*(13-k)-1 : 128*(12-k)], MS word first (round key 0 at top, round key 12 at [127:0])
o_key_ok  out  1  level; 1 = o_keyex holds a complete schedule for the last loaded key
o_busy  out  1  level; 1 while expansion groups are being computed
o_sbox_din  out  32  RotWord(w[i-1]) = {w[23:0],w[31:24]} to external S-box
i_sbox_dout  in  32  S-box result, same cycle (combinational return)

Behaviour:
- Reset (synchronous, i_rst=1 at edge): o_keyex=0, o_key_ok=0, o_busy=0, round counter r_count=0. Reset mid-expansion aborts the expansion, and the schedule is discarded.
- Load: i_key_en=1 at edge E0 -> words w0..w5 written with i_key, r_count=1, o_key_ok=0, o_busy=1. Words w6..w51 are not cleared.
- Expand: while r_count=j (1..8), one group is computed combinationally from the last written group:
  - t = SubWord(RotWord(w[6j-1])) ^ {Rcon[j],24'h0}
  - w[6j] = w[6j-6]^t
  - w[6j+m] = w[6j+m-6]^w[6j+m-1], m=1..5
  - The group is written at edge Ej.
  - j=8 writes only w48..w51, since w52/w53 are not stored.
- Rcon[1..8] = 01,02,04,08,10,20,40,80.
- o_sbox_din always carries RotWord of the last word of the group indexed by r_count. Its value is don't-care when r_count=0.
- Completion: at edge E8, r_count->0, o_busy->0, o_key_ok->1. The latency from the i_key_en edge to o_key_ok high is exactly 8 clocks.
- Hold: with r_count=0 and no i_key_en, o_keyex and o_key_ok hold indefinitely.
- i_key_en during expansion (any r_count 1..8, including at E8): restart with the new key, r_count=1, and o_key_ok stays 0. Restart has priority over completion.
- i_rst and i_key_en together: reset wins.
- o_keyex is the internal word register itself. Consumers must gate on o_key_ok, because partial contents during o_busy are undefined for use.
- All arithmetic is bitwise XOR on 32-bit words; there is no carry.

Decomposition:
- Shared package aes_pkg: AES192_NK=6, AES192_NR=12, AES192_NW=52, Rcon byte table, RotWord function, round-key slice index helper (shared with the data-path core).
- One natural sub-module: aes192_kex_grp, the combinational 6-word group generator (inputs: previous group, S-box result, Rcon byte; output: new group).
- The FSM (idle/expand via r_count) and word storage stay in aes192_kex.
- The S-box remains external and is shared at the top level.

Test Plan:
- FIPS-197 A.2 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, one i_key_en pulse -> o_key_ok rises exactly 8 clocks later; w6=fe0c91f7, w7=2402f5a5, w48..w51 = e98ba06f 448c773c 8ecc7204 01002202 (o_keyex[127:0]).
- Same key: check o_busy=1 for exactly 8 cycles; o_sbox_din at r_count=1 = RotWord(w5=522c6b7b) = 2c6b7b52.
- Key 000102...1617 expanded, then fed with o_keyex to the data-path core, plaintext 00112233445566778899aabbccddeeff -> ciphertext dda97ca4864cdfe06eaf70a0ec0d7191; decrypt of that ciphertext returns the plaintext.
- Load key A, re-pulse i_key_en with key B at r_count=4 -> o_key_ok low until 8 clocks after the second pulse; schedule equals the reference schedule of key B.
- Assert i_rst at r_count=5 -> next cycle o_keyex=0, o_key_ok=0, o_busy=0; a fresh load then completes normally.
- Pulse i_key_en on the same edge as completion (E8) -> o_key_ok stays 0 and completes 8 clocks later with the new key.
